sysclk_rst_monitor: RTL and testbench

- Observing counterpart of the testbench clock/reset generator: samples an observed clock and reset with a local reference clock.
- Measures the observed clock's period and high time, and the reset pulse width, in reference cycles.
- Flags out-of-range period or duty, a stopped clock, and a too-short reset.
- Sits beside the DUT clock/reset pins in sim and can be instantiated on-chip as a synthesizable clock-health monitor.

---
 rtl/sysclk_mon_pkg.sv | 35 +++
 rtl/sysclk_mon_sync.sv | 25 ++
 rtl/sysclk_rst_monitor.sv | 164 ++++++++++++++++
 tb/tb_sysclk_rst_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sysclk_mon_pkg.sv
// Shared types and saturating arithmetic for the sysclk_rst_monitor slice.
// Counters are limited to 32 bits by the helper width SAT_W.
package sysclk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2,
    STOPPED = 2'd3
  } mon_state_e;

  localparam int unsigned SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_max(input int unsigned w);
    return (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned w);
    logic [SAT_W-1:0] max_v;
    max_v = sat_max(w);
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned w);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] max_v;
    max_v = sat_max(w);
    sum   = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/sysclk_mon_sync.sv
// Two-flop synchronizer plus a third flop for edge detection.
// Flops reset to RST_VAL so an input already at that level shows no edge.
module sysclk_mon_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= {3{RST_VAL}};
    else          sync_q <= {sync_q[1:0], din};
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/sysclk_rst_monitor.sv
// Clock/reset health monitor: measures period, high time and reset width.
// Define SYSCLK_MON_MINMAX_EN to build min/max period tracking.
module sysclk_rst_monitor
  import sysclk_mon_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned PERIOD_MIN   = 8,
  parameter int unsigned PERIOD_MAX   = 12,
  parameter int unsigned HIGH_MIN     = 3,
  parameter int unsigned HIGH_MAX     = 7,
  parameter int unsigned STOP_TIMEOUT = 20,
  parameter logic        RST_POL      = 1'b0,
  parameter int unsigned RST_MIN      = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             mon_clk_i,
  input  logic             mon_rst_i,
  input  logic             err_clr_i,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             clk_stopped_o,
  output logic             period_err_o,
  output logic             duty_err_o,
  output logic             rst_done_o,
  output logic [CNT_W-1:0] rst_len_o,
  output logic             rst_short_o,
  output logic [CNT_W-1:0] period_min_o,
  output logic [CNT_W-1:0] period_max_o
);

  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] H_MIN   = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] STOP_TO = CNT_W'(STOP_TIMEOUT);
  localparam logic [CNT_W-1:0] R_MIN   = CNT_W'(RST_MIN);

  logic clk_rise, clk_fall, clk_level_unused;
  logic rst_rise, rst_fall, rst_level;

  sysclk_mon_sync #(.RST_VAL(1'b0)) u_clk_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din     (mon_clk_i),
    .rise    (clk_rise),
    .fall    (clk_fall),
    .level   (clk_level_unused)
  );

  sysclk_mon_sync #(.RST_VAL(~RST_POL)) u_rst_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din     (mon_rst_i),
    .rise    (rst_rise),
    .fall    (rst_fall),
    .level   (rst_level)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] high_cnt, low_cnt, high_len, idle_cnt, rst_cnt;
  logic [CNT_W-1:0] idle_nxt, period_new;
  logic             idle_hit, meas_fire, period_viol, duty_viol;
  logic             rst_deassert, rst_viol;

  assign idle_hit = (idle_cnt >= STOP_TO);
  assign idle_nxt = (clk_rise | clk_fall) ? '0
                                          : CNT_W'(sat_inc(SAT_W'(idle_cnt), CNT_W));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clk_rise) state_d = HIGH;
      HIGH:    if (clk_fall) state_d = LOW;
               else if (idle_hit) state_d = STOPPED;
      LOW:     if (clk_rise) state_d = HIGH;
               else if (idle_hit) state_d = STOPPED;
      STOPPED: if (clk_rise) state_d = HIGH;
      default: state_d = IDLE;
    endcase
  end

  // Only a rise that closes a LOW phase completes a full period.
  always_comb begin
    meas_fire    = (state_q == LOW) && clk_rise;
    period_new   = CNT_W'(sat_add(SAT_W'(high_len), SAT_W'(low_cnt), CNT_W));
    period_viol  = (period_new < P_MIN) || (period_new > P_MAX) || (period_new == '1);
    duty_viol    = (high_len < H_MIN) || (high_len > H_MAX);
    rst_deassert = RST_POL ? rst_fall : rst_rise;
    rst_viol     = (rst_cnt < R_MIN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      high_cnt      <= '0;
      low_cnt       <= '0;
      high_len      <= '0;
      idle_cnt      <= '0;
      rst_cnt       <= '0;
      meas_valid_o  <= 1'b0;
      period_o      <= '0;
      high_o        <= '0;
      clk_stopped_o <= 1'b0;
      period_err_o  <= 1'b0;
      duty_err_o    <= 1'b0;
      rst_done_o    <= 1'b0;
      rst_len_o     <= '0;
      rst_short_o   <= 1'b0;
    end else begin
      high_cnt      <= clk_rise ? CNT_W'(1) : CNT_W'(sat_inc(SAT_W'(high_cnt), CNT_W));
      low_cnt       <= clk_fall ? CNT_W'(1) : CNT_W'(sat_inc(SAT_W'(low_cnt), CNT_W));
      if (clk_fall) high_len <= high_cnt;
      idle_cnt      <= idle_nxt;
      clk_stopped_o <= (idle_nxt >= STOP_TO);
      meas_valid_o  <= meas_fire;
      if (meas_fire) begin
        period_o <= period_new;
        high_o   <= high_len;
      end
      // A violation in the clear cycle keeps the flag set.
      period_err_o  <= (meas_fire && period_viol) || (period_err_o && !err_clr_i);
      duty_err_o    <= (meas_fire && duty_viol)   || (duty_err_o   && !err_clr_i);
      rst_done_o    <= rst_deassert;
      if (rst_deassert) begin
        rst_len_o <= rst_cnt;
        rst_cnt   <= '0;
      end else if (rst_level == RST_POL) begin
        rst_cnt   <= CNT_W'(sat_inc(SAT_W'(rst_cnt), CNT_W));
      end
      rst_short_o   <= (rst_deassert && rst_viol) || (rst_short_o && !err_clr_i);
    end
  end

`ifdef SYSCLK_MON_MINMAX_EN
  logic [CNT_W-1:0] pmin_base, pmax_base, pmin_nxt, pmax_nxt;

  always_comb begin
    pmin_base = err_clr_i ? '1 : period_min_o;
    pmax_base = err_clr_i ? '0 : period_max_o;
    pmin_nxt  = (meas_fire && (period_new < pmin_base)) ? period_new : pmin_base;
    pmax_nxt  = (meas_fire && (period_new > pmax_base)) ? period_new : pmax_base;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_min_o <= '1;
      period_max_o <= '0;
    end else begin
      period_min_o <= pmin_nxt;
      period_max_o <= pmax_nxt;
    end
  end
`else
  assign period_min_o = '0;
  assign period_max_o = '0;
`endif

endmodule

// File: tb/tb_sysclk_rst_monitor.sv
// Directed bench for sysclk_rst_monitor; expectations are hand-computed in
// reference cycles (mon clock edges placed away from clk_i rising edges).
module tb_sysclk_rst_monitor;

  localparam int unsigned CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_n_i, mon_clk_i, mon_rst_i, err_clr_i;
  logic             meas_valid_o, clk_stopped_o, period_err_o, duty_err_o;
  logic             rst_done_o, rst_short_o;
  logic [CNT_W-1:0] period_o, high_o, rst_len_o, period_min_o, period_max_o;

  int n_vec = 0;
  int n_err = 0;
  int meas_cnt = 0;
  int done_cnt = 0;
  int m0, d0;
  logic [CNT_W-1:0] last_p = '0;
  logic [CNT_W-1:0] last_h = '0;

  sysclk_rst_monitor dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .mon_clk_i     (mon_clk_i),
    .mon_rst_i     (mon_rst_i),
    .err_clr_i     (err_clr_i),
    .meas_valid_o  (meas_valid_o),
    .period_o      (period_o),
    .high_o        (high_o),
    .clk_stopped_o (clk_stopped_o),
    .period_err_o  (period_err_o),
    .duty_err_o    (duty_err_o),
    .rst_done_o    (rst_done_o),
    .rst_len_o     (rst_len_o),
    .rst_short_o   (rst_short_o),
    .period_min_o  (period_min_o),
    .period_max_o  (period_max_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (meas_valid_o) begin
      meas_cnt = meas_cnt + 1;
      last_p   = period_o;
      last_h   = high_o;
    end
    if (rst_done_o) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic ok;
    ok = (obs + 32'd1 >= exp) && (obs <= exp + 32'd1);
    n_vec++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d+-1", tag, obs, exp);
    end
  endtask

  task automatic mon_cycles(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      mon_clk_i = 1'b1; #(hi);
      mon_clk_i = 1'b0; #(lo);
    end
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1; #10;
    err_clr_i = 1'b0;
  endtask

  initial begin
    #2;
    rst_n_i = 1'b0; mon_clk_i = 1'b0; mon_rst_i = 1'b1; err_clr_i = 1'b0;
    #30;
    check("rst_meas_valid", meas_valid_o, 0);
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    check("rst_stopped", clk_stopped_o, 0);
    check("rst_period_err", period_err_o, 0);
    check("rst_duty_err", duty_err_o, 0);
    check("rst_done", rst_done_o, 0);
    check("rst_len", rst_len_o, 0);
    check("rst_short", rst_short_o, 0);
`ifdef SYSCLK_MON_MINMAX_EN
    check("rst_pmin", period_min_o, 32'h0000_FFFF);
`else
    check("rst_pmin", period_min_o, 0);
`endif
    check("rst_pmax", period_max_o, 0);
    rst_n_i = 1'b1;
    #20;

    // 100-unit period, 50 % duty: first period discarded
    m0 = meas_cnt;
    mon_cycles(50, 50, 6);
    check("nom_meas_count", meas_cnt - m0, 5);
    check_near("nom_period", last_p, 10);
    check_near("nom_high", last_h, 5);
    check("nom_period_err", period_err_o, 0);
    check("nom_duty_err", duty_err_o, 0);
    check("nom_stopped", clk_stopped_o, 0);

    // 20 % duty
    mon_cycles(20, 80, 4);
    check_near("duty20_high", last_h, 2);
    check_near("duty20_period", last_p, 10);
    check("duty20_duty_err", duty_err_o, 1);
    check("duty20_period_err", period_err_o, 0);
    mon_cycles(50, 50, 2);
    check("duty_sticky", duty_err_o, 1);
    pulse_clr();
    check("duty_cleared", duty_err_o, 0);
    mon_cycles(50, 50, 2);
    check("duty_stays_clear", duty_err_o, 0);
    check("period_err_clean", period_err_o, 0);

    // 160-unit period
    mon_cycles(80, 80, 3);
    check_near("slow_period", last_p, 16);
    check_near("slow_high", last_h, 8);
    check("slow_period_err", period_err_o, 1);
    check("slow_duty_err", duty_err_o, 1);
`ifdef SYSCLK_MON_MINMAX_EN
    check_near("mix_pmin", period_min_o, 10);
    check_near("mix_pmax", period_max_o, 16);
`else
    check("mix_pmin", period_min_o, 0);
    check("mix_pmax", period_max_o, 0);
`endif

    // Stopped clock: last fall was 80 units ago
    #70;
    check("stop_not_yet", clk_stopped_o, 0);
    #150;
    check("stop_declared", clk_stopped_o, 1);
    pulse_clr();
    check("stop_clr_period_err", period_err_o, 0);
    check("stop_clr_duty_err", duty_err_o, 0);
`ifdef SYSCLK_MON_MINMAX_EN
    check("clr_pmin", period_min_o, 32'h0000_FFFF);
`else
    check("clr_pmin", period_min_o, 0);
`endif
    check("clr_pmax", period_max_o, 0);
    #100;
    m0 = meas_cnt;
    mon_clk_i = 1'b1; #40;
    check("restart_stopped_drop", clk_stopped_o, 0);
    check("restart_no_meas", meas_cnt - m0, 0);
    #10;
    mon_clk_i = 1'b0; #50;
    mon_cycles(50, 50, 2);
    check("restart_meas_count", meas_cnt - m0, 2);
    check_near("restart_period", last_p, 10);
    check_near("restart_high", last_h, 5);
    check("restart_period_err", period_err_o, 0);
    check("restart_duty_err", duty_err_o, 0);
`ifdef SYSCLK_MON_MINMAX_EN
    check_near("restart_pmax", period_max_o, 10);
`else
    check("restart_pmax", period_max_o, 0);
`endif

    // Observed reset widths
    d0 = done_cnt;
    mon_rst_i = 1'b0; #30;
    mon_rst_i = 1'b1; #60;
    check("rst30_done", done_cnt - d0, 1);
    check_near("rst30_len", rst_len_o, 3);
    check("rst30_short", rst_short_o, 1);
    pulse_clr();
    check("rst_short_cleared", rst_short_o, 0);
    mon_rst_i = 1'b0; #100;
    mon_rst_i = 1'b1; #60;
    check("rst100_done", done_cnt - d0, 2);
    check_near("rst100_len", rst_len_o, 10);
    check("rst100_short", rst_short_o, 0);

    // Local reset in the middle of a high phase
    mon_cycles(50, 50, 2);
    mon_clk_i = 1'b1; #23;
    rst_n_i = 1'b0; #1;
    check("async_period", period_o, 0);
    check("async_high", high_o, 0);
    check("async_rst_len", rst_len_o, 0);
    check("async_stopped", clk_stopped_o, 0);
    check("async_meas_valid", meas_valid_o, 0);
    #26;
    mon_clk_i = 1'b0; #20;
    rst_n_i = 1'b1; #30;
    m0 = meas_cnt;
    mon_clk_i = 1'b1; #50;
    mon_clk_i = 1'b0; #45;
    check("post_rst_no_meas", meas_cnt - m0, 0);
    #5;
    mon_cycles(50, 50, 1);
    check("post_rst_meas", meas_cnt - m0, 1);
    check_near("post_rst_period", last_p, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
